// File: rtl/seq_det_pkg.sv
// Shared types and helpers for the parametrised Moore pattern detector.
// Holds the prefix-matching function used by the next-state logic.
package seq_det_pkg;

   localparam int MAX_PAT_W   = 16;
   localparam int DEF_PAT_W   = 4;
   localparam int DEF_CNT_W   = 8;
   localparam int DEF_STATE_W = $clog2(DEF_PAT_W + 1);
   localparam int DEF_CNT_MAX = (1 << DEF_CNT_W) - 1;

   typedef enum logic [1:0] {
      ACT_HOLD,
      ACT_ACCEPT,
      ACT_LOAD,
      ACT_RESET
   } act_t;

   // Longest k (k <= pat_w, k <= max_k) for which the newest k bits of {h, in_bit}
   // equal the first k pattern bits p[pat_w-1 -: k]. max_k = PS+1 keeps k inside
   // the bits actually accepted since the last reset, load or discard.
   function automatic int longest_prefix(input logic [MAX_PAT_W-1:0] h,
                                         input logic                 in_bit,
                                         input logic [MAX_PAT_W-1:0] p,
                                         input int                   pat_w,
                                         input int                   max_k);
      logic [MAX_PAT_W:0] seq;
      logic               ok;
      int                 best;
      seq  = {h, in_bit};
      best = 0;
      for (int k = 1; k <= MAX_PAT_W; k++) begin
         if (k <= pat_w && k <= max_k) begin
            ok = 1'b1;
            for (int i = 0; i < MAX_PAT_W; i++) begin
               if (i < k && seq[5'(i)] != p[4'(pat_w - k + i)])
                  ok = 1'b0;
            end
            if (ok)
               best = k;
         end
      end
      return best;
   endfunction

endpackage

// File: rtl/seq_detect_moore_param_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inc,
   input  logic             clr,
   output logic [CNT_W-1:0] count
);

   always_ff @(posedge clk) begin
      if (rst || clr)
         count <= '0;
      else if (inc && count != {CNT_W{1'b1}})
         count <= count + 1'b1;
   end

endmodule

// File: rtl/seq_detect_moore_param.sv
// Moore serial pattern detector: PS counts matched leading pattern bits,
// OUT is high while PS == PAT_W, completed matches feed a saturating counter.
module seq_detect_moore_param
   import seq_det_pkg::*;
#(
   parameter int               PAT_W   = 4,
   parameter logic [PAT_W-1:0] PATTERN = 4'b1011,
   parameter bit               OVERLAP = 1'b1,
   parameter int               CNT_W   = 8
) (
   input  logic                         CK,
   input  logic                         R,
   input  logic                         EN,
   input  logic                         IN,
   input  logic                         PAT_LD,
   input  logic [PAT_W-1:0]             PAT_IN,
   input  logic                         CNT_CLR,
   output logic                         OUT,
   output logic [CNT_W-1:0]             MATCH_CNT,
   output logic [$clog2(PAT_W+1)-1:0]   STATE
);

   localparam int SW = $clog2(PAT_W + 1);

   if (PAT_W < 2 || PAT_W > MAX_PAT_W) begin : g_bad_pat_w
      $error("seq_detect_moore_param: PAT_W must be in 2..%0d", MAX_PAT_W);
   end

   logic [PAT_W-1:0] p_q, p_d;
   logic [PAT_W-1:0] h_q, h_d;
   logic [SW-1:0]    ps_q, ps_d;
   logic             full;
   logic             hit;
   act_t             act;
   int               max_k;

   assign full = (ps_q == SW'(PAT_W));

   always_ff @(posedge CK) begin
      p_q  <= p_d;
      h_q  <= h_d;
      ps_q <= ps_d;
   end

   always_comb begin
      p_d   = p_q;
      h_d   = h_q;
      ps_d  = ps_q;
      hit   = 1'b0;
      max_k = 0;
      if (R)
         act = ACT_RESET;
      else if (PAT_LD)
         act = ACT_LOAD;
      else if (EN)
         act = ACT_ACCEPT;
      else
         act = ACT_HOLD;

      case (act)
         ACT_RESET: begin
            p_d  = PATTERN;
            h_d  = '0;
            ps_d = '0;
         end
         ACT_LOAD: begin
            p_d  = PAT_IN;
            h_d  = '0;
            ps_d = '0;
         end
         ACT_ACCEPT: begin
            // Non-overlap restarts from the current bit once a match has been shown.
            if (!OVERLAP && full) begin
               max_k = 1;
               h_d   = {{(PAT_W-1){1'b0}}, IN};
            end else begin
               max_k = int'(ps_q) + 1;
               h_d   = {h_q[PAT_W-2:0], IN};
            end
            ps_d = SW'(longest_prefix(MAX_PAT_W'(h_q), IN, MAX_PAT_W'(p_q), PAT_W, max_k));
            hit  = (ps_d == SW'(PAT_W));
         end
         default: ;
      endcase
   end

   sat_counter #(
      .CNT_W (CNT_W)
   ) u_cnt (
      .clk   (CK),
      .rst   (R),
      .inc   (hit),
      .clr   (CNT_CLR),
      .count (MATCH_CNT)
   );

   assign OUT   = full;
   assign STATE = ps_q;

endmodule

// File: tb/tb_seq_detect_moore_param.sv
// Scoreboard bench: three detector configurations share one stimulus stream and are
// checked each cycle against a history-buffer reference model.
module tb_seq_detect_moore_param;

   logic        ck = 1'b0;
   logic        r = 1'b1, en = 1'b0, in_b = 1'b0, ld = 1'b0, clr = 1'b0;
   logic [15:0] pin = '0;

   logic       out_a, out_b, out_c;
   logic [7:0] cnt_a, cnt_b;
   logic [1:0] cnt_c;
   logic [2:0] st_a, st_b;
   logic [1:0] st_c;

   always #5 ck = ~ck;

   seq_detect_moore_param #(.PAT_W(4), .PATTERN(4'b1011), .OVERLAP(1'b1), .CNT_W(8)) dut_a (
      .CK(ck), .R(r), .EN(en), .IN(in_b), .PAT_LD(ld), .PAT_IN(pin[3:0]), .CNT_CLR(clr),
      .OUT(out_a), .MATCH_CNT(cnt_a), .STATE(st_a));
   seq_detect_moore_param #(.PAT_W(4), .PATTERN(4'b1011), .OVERLAP(1'b0), .CNT_W(8)) dut_b (
      .CK(ck), .R(r), .EN(en), .IN(in_b), .PAT_LD(ld), .PAT_IN(pin[3:0]), .CNT_CLR(clr),
      .OUT(out_b), .MATCH_CNT(cnt_b), .STATE(st_b));
   seq_detect_moore_param #(.PAT_W(2), .PATTERN(2'b11), .OVERLAP(1'b1), .CNT_W(2)) dut_c (
      .CK(ck), .R(r), .EN(en), .IN(in_b), .PAT_LD(ld), .PAT_IN(pin[1:0]), .CNT_CLR(clr),
      .OUT(out_c), .MATCH_CNT(cnt_c), .STATE(st_c));

   // Reference model: a record of accepted bits (newest in bit 0) per configuration.
   int pw[3]   = '{4, 4, 2};
   int ov[3]   = '{1, 0, 1};
   int cmax[3] = '{255, 255, 3};
   int pinit[3] = '{'b1011, 'b1011, 'b11};
   int pat[3], hist[3], nval[3], ps[3], cnt[3];

   typedef struct { int inst; int out; int cnt; int st; } exp_t;
   exp_t sbq[$];

   int errors = 0;
   int checks = 0;

   function automatic int model_ns(int i);
      int lim;
      lim = (nval[i] < pw[i]) ? nval[i] : pw[i];
      for (int k = lim; k >= 1; k--) begin
         if ((hist[i] & ((1 << k) - 1)) == (pat[i] >> (pw[i] - k)))
            return k;
      end
      return 0;
   endfunction

   task automatic model_edge();
      exp_t e;
      bit   match;
      for (int i = 0; i < 3; i++) begin
         match = 0;
         if (r) begin
            pat[i] = pinit[i]; hist[i] = 0; nval[i] = 0; ps[i] = 0; cnt[i] = 0;
         end else begin
            if (ld) begin
               pat[i] = int'(pin) & ((1 << pw[i]) - 1);
               hist[i] = 0; nval[i] = 0; ps[i] = 0;
            end else if (en) begin
               if (ov[i] == 0 && ps[i] == pw[i]) begin
                  hist[i] = 0; nval[i] = 0;
               end
               hist[i] = ((hist[i] << 1) | int'(in_b)) & 'hFFFF;
               if (nval[i] < 16) nval[i]++;
               ps[i] = model_ns(i);
               match = (ps[i] == pw[i]);
            end
            if (clr) cnt[i] = 0;
            else if (match && cnt[i] < cmax[i]) cnt[i]++;
         end
         e.inst = i; e.out = (ps[i] == pw[i]) ? 1 : 0; e.cnt = cnt[i]; e.st = ps[i];
         sbq.push_back(e);
      end
   endtask

   task automatic step(input logic rr, input logic ee, input logic ii,
                       input logic ll, input logic [15:0] pp, input logic cc);
      r = rr; en = ee; in_b = ii; ld = ll; pin = pp; clr = cc;
      @(posedge ck);
      model_edge();
      #2;
   endtask

   task automatic bits(input int n, input logic [15:0] v);
      for (int j = n - 1; j >= 0; j--) step(0, 1, v[j], 0, 16'h0, 0);
   endtask

   task automatic dcheck(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, req);
      end
   endtask

   // Monitor: one scoreboard entry per configuration after every edge.
   initial begin
      exp_t e;
      int   ao, ac, as;
      forever begin
         @(posedge ck);
         #1;
         while (sbq.size() > 0) begin
            e = sbq.pop_front();
            case (e.inst)
               0:       begin ao = int'(out_a); ac = int'(cnt_a); as = int'(st_a); end
               1:       begin ao = int'(out_b); ac = int'(cnt_b); as = int'(st_b); end
               default: begin ao = int'(out_c); ac = int'(cnt_c); as = int'(st_c); end
            endcase
            checks += 3;
            if (ao != e.out) begin
               errors++; $display("FAIL out[%0d] t=%0t: got %0d, expected %0d", e.inst, $time, ao, e.out);
            end
            if (ac != e.cnt) begin
               errors++; $display("FAIL match_cnt[%0d] t=%0t: got %0d, expected %0d", e.inst, $time, ac, e.cnt);
            end
            if (as != e.st) begin
               errors++; $display("FAIL state[%0d] t=%0t: got %0d, expected %0d", e.inst, $time, as, e.st);
            end
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
      $fatal(1, "watchdog");
   end

   initial begin
      step(1, 0, 0, 0, 16'h0, 0);
      dcheck("reset_state_a", int'(st_a), 0);
      dcheck("reset_cnt_a", int'(cnt_a), 0);

      // Basic match 1011
      bits(3, 16'b101);
      dcheck("state_after_101", int'(st_a), 3);
      bits(1, 16'b1);
      dcheck("out_after_1011", int'(out_a), 1);
      dcheck("cnt_after_1011", int'(cnt_a), 1);

      // Overlap vs non-overlap
      step(1, 0, 0, 0, 16'h0, 0);
      bits(7, 16'b1011011);
      dcheck("overlap_cnt", int'(cnt_a), 2);
      dcheck("nonoverlap_cnt", int'(cnt_b), 1);
      dcheck("nonoverlap_state", int'(st_b), 1);

      // EN gap
      step(1, 0, 0, 0, 16'h0, 0);
      bits(2, 16'b10);
      for (int j = 0; j < 3; j++) step(0, 0, j[0], 0, 16'h0, 0);
      dcheck("state_hold_gap", int'(st_a), 2);
      bits(2, 16'b11);
      dcheck("gap_cnt", int'(cnt_a), 1);

      // Runtime pattern load
      step(1, 0, 0, 0, 16'h0, 0);
      bits(3, 16'b101);
      step(0, 1, 1, 1, 16'b0110, 0);
      dcheck("state_after_load", int'(st_a), 0);
      bits(4, 16'b0110);
      dcheck("out_new_pattern", int'(out_a), 1);
      bits(4, 16'b1011);
      dcheck("old_pattern_no_match", int'(cnt_a), 1);

      // Saturation on the 2-bit configuration, then clear against a match
      step(1, 0, 0, 0, 16'h0, 0);
      bits(6, 16'b111111);
      dcheck("sat_cnt_c", int'(cnt_c), 3);
      step(0, 1, 1, 0, 16'h0, 1);
      dcheck("clr_wins_c", int'(cnt_c), 0);

      // Reset mid-match
      step(1, 0, 0, 0, 16'h0, 0);
      bits(3, 16'b101);
      step(1, 1, 1, 0, 16'h0, 0);
      bits(1, 16'b1);
      dcheck("mid_reset_state", int'(st_a), 1);
      dcheck("mid_reset_out", int'(out_a), 0);

      // Randomised traffic
      for (int n = 0; n < 4000; n++) begin
         step(($urandom_range(0, 99) == 0),
              ($urandom_range(0, 3) != 0),
              1'($urandom),
              ($urandom_range(0, 39) == 0),
              16'($urandom),
              ($urandom_range(0, 49) == 0));
      end

      step(0, 0, 0, 0, 16'h0, 0);
      @(posedge ck);
      #3;
      dcheck("scoreboard_drained", sbq.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
